rvfi_bus_responder: RTL
=======================

Name: rvfi_bus_responder

Overview:
- Parametrised, multi-channel Wishbone classic/registered-burst responder for core formal and simulation harnesses.
- Sits between the core's bus masters (ibus, dbus, ...) and free/random stimulus inputs.
- Produces ack/dat_r/err per channel with a guaranteed bounded wait, replacing per-wrapper fairness logic.
- Checks master-side protocol: request stability, burst addressing and abandoned strobes. Raises sticky per-channel error flags.

Parameters:
- NCHAN, 2, number of independent bus channels.
- ADR_W, 30, word address width.
- DAT_W, 32, data width; SEL_W = DAT_W/8.
- MAX_WAIT, 2, max cycles a request may stay unterminated; forced ack at wait_cnt == MAX_WAIT; 0 = ack every active cycle.
- CNT_W, 2, width of wait_cnt; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cyc  in  NCHAN  master cycle, one bit per channel.
- stb  in  NCHAN  master strobe.
- we  in  NCHAN  write enable.
- adr  in  NCHAN*ADR_W  word addresses; channel i at [i*ADR_W +: ADR_W].
- sel  in  NCHAN*SEL_W  byte selects.
- dat_w  in  NCHAN*DAT_W  write data.
- cti  in  NCHAN*3  cycle type identifier.
- bte  in  NCHAN*2  burst type extension.
- rand_ack  in  NCHAN  free/random ack request.
- rand_dat  in  NCHAN*DAT_W  free/random read data.
- ack  out  NCHAN  termination ack.
- err  out  NCHAN  termination error; 0 unless RVFI_BUS_ERR_EN.
- dat_r  out  NCHAN*DAT_W  read data.
- wait_cnt  out  NCHAN*CNT_W  current wait count per channel.
- proto_err  out  NCHAN  sticky protocol violation flag.

Behaviour:
- Per channel: active = cyc & stb. Channels are fully independent.
- Termination is combinational in the same cycle:
  - forced = active & (wait_cnt == MAX_WAIT).
  - ack = active & (rand_ack | forced) & ~err.
- dat_r = rand_dat when ack & ~we, else 0.
- wait_cnt:
  - 0 on reset, and in any cycle where active is low or ack|err is high.
  - Otherwise increments by 1; never exceeds MAX_WAIT.
- FSM per channel, states IDLE, WAIT, BURST. Reset state IDLE.
- IDLE:
  - active & ~(ack|err): capture adr/we/sel/dat_w, go to WAIT.
  - ack with cti==3'b010 & bte==2'b00: capture adr, go to BURST.
  - Otherwise stay in IDLE.
- WAIT:
  - Each cycle, adr/we/sel (and dat_w when we=1) must equal the captured values. On mismatch, set proto_err.
  - stb low while cyc high sets proto_err (abandoned request), go to IDLE.
  - cyc low: go to IDLE, no error (abort).
  - Termination: go to BURST if cti==010 & bte==00, else go to IDLE.
- BURST:
  - Next active beat must have adr == captured_adr + 1 (wraps modulo 2^ADR_W). Violation sets proto_err.
  - Beat terminated with cti==3'b111 or cti==3'b000: go to IDLE.
  - Beat terminated with cti==010: recapture adr, stay in BURST.
  - Beat not terminated: behaves like WAIT (stability check), remaining in BURST.
  - cyc low: go to IDLE, no error.
  - bte != 00 with cti==010 in any state: proto_err (only linear bursts supported).
- proto_err is sticky until reset. Checking continues after the first error.
- Simultaneous rand_ack and forced: single ack, no double count.
- Reset asserted mid-transfer clears all outputs, state and captured values immediately (async). ack/err/dat_r go to 0 through their active terms only if cyc/stb are also low; the combinational path is not gated by reset.

Optional Feature:
- RVFI_BUS_ERR_EN defined:
  - Adds input port rand_err [NCHAN].
  - err = active & rand_err, including when forced; err takes priority over ack.
  - err terminates a burst and returns the FSM to IDLE.
- Undefined: rand_err port absent, err tied to 0, all terminations are acks.

Test Plan:
- MAX_WAIT=2, ch0 cyc=stb=1, rand_ack=0 held -> ack=0, 0, 1 on cycles 0, 1, 2; wait_cnt 0, 1, 2, then 0; proto_err=0.
- Read, we=0, rand_ack=1, rand_dat=32'hDEADBEEF -> same-cycle ack=1, dat_r=32'hDEADBEEF; with we=1 -> dat_r=0.
- Adr changes 0x100->0x104 during wait, before ack -> proto_err[0]=1 next cycle and stays 1; ch1 proto_err stays 0.
- Burst cti=010: adr 0x40, 0x41, 0x42 then 0x43 with cti=111, all acked -> proto_err=0, FSM IDLE. Repeat with 0x40 then 0x42 -> proto_err=1.
- cyc=stb=1 at wait_cnt=1, then reset pulse -> wait_cnt=0, proto_err=0, FSM IDLE immediately, without a clock edge.
- RVFI_BUS_ERR_EN: rand_err=1 and rand_ack=1 in the same cycle -> err=1, ack=0; burst in progress exits to IDLE.

Source files
------------

// File: rtl/rvfi_bus_responder.sv
// Multi-channel Wishbone classic/registered-burst responder with bounded wait and master protocol checks.
// Define RVFI_BUS_ERR_EN to add the rand_err input and enable error terminations.
module rvfi_bus_responder #(
   parameter int NCHAN    = 2,
   parameter int ADR_W    = 30,
   parameter int DAT_W    = 32,
   parameter int MAX_WAIT = 2,
   parameter int CNT_W    = 2,
   localparam int SEL_W   = DAT_W / 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NCHAN-1:0]         cyc,
   input  logic [NCHAN-1:0]         stb,
   input  logic [NCHAN-1:0]         we,
   input  logic [NCHAN*ADR_W-1:0]   adr,
   input  logic [NCHAN*SEL_W-1:0]   sel,
   input  logic [NCHAN*DAT_W-1:0]   dat_w,
   input  logic [NCHAN*3-1:0]       cti,
   input  logic [NCHAN*2-1:0]       bte,
   input  logic [NCHAN-1:0]         rand_ack,
   input  logic [NCHAN*DAT_W-1:0]   rand_dat,
`ifdef RVFI_BUS_ERR_EN
   input  logic [NCHAN-1:0]         rand_err,
`endif
   output logic [NCHAN-1:0]         ack,
   output logic [NCHAN-1:0]         err,
   output logic [NCHAN*DAT_W-1:0]   dat_r,
   output logic [NCHAN*CNT_W-1:0]   wait_cnt,
   output logic [NCHAN-1:0]         proto_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2
   } state_t;

   localparam logic [2:0] CTI_INCR = 3'b010;

   for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
      state_t             state_q, state_d;
      logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
      logic [ADR_W-1:0]   cap_adr_q, cap_adr_d;
      logic               cap_we_q, cap_we_d;
      logic [SEL_W-1:0]   cap_sel_q, cap_sel_d;
      logic [DAT_W-1:0]   cap_dat_q, cap_dat_d;
      logic               beat_q, beat_d;
      logic               proto_err_q, proto_err_d;

      logic               c_cyc, c_stb, c_we;
      logic [ADR_W-1:0]   c_adr, next_adr;
      logic [SEL_W-1:0]   c_sel;
      logic [DAT_W-1:0]   c_dat, c_dat_r;
      logic [2:0]         c_cti;
      logic [1:0]         c_bte;
      logic               active, forced, c_ack, c_err, term;
      logic               burst_req, bad_bte, stable, violation;

      assign c_cyc    = cyc[gi];
      assign c_stb    = stb[gi];
      assign c_we     = we[gi];
      assign c_adr    = adr[gi*ADR_W +: ADR_W];
      assign c_sel    = sel[gi*SEL_W +: SEL_W];
      assign c_dat    = dat_w[gi*DAT_W +: DAT_W];
      assign c_cti    = cti[gi*3 +: 3];
      assign c_bte    = bte[gi*2 +: 2];
      assign active   = c_cyc & c_stb;
      assign next_adr = cap_adr_q + ADR_W'(1);

      assign burst_req = (c_cti == CTI_INCR) && (c_bte == 2'b00);
      assign bad_bte   = active && (c_cti == CTI_INCR) && (c_bte != 2'b00);
      assign stable    = (c_adr == cap_adr_q) && (c_we == cap_we_q) && (c_sel == cap_sel_q)
                         && (!cap_we_q || (c_dat == cap_dat_q));

      // Termination is purely combinational so a beat completes in the cycle it is presented.
      always_comb begin
         c_err = 1'b0;
`ifdef RVFI_BUS_ERR_EN
         c_err = active & rand_err[gi];
`endif
         forced     = active & (wait_cnt_q == CNT_W'(MAX_WAIT));
         c_ack      = active & (rand_ack[gi] | forced) & ~c_err;
         term       = c_ack | c_err;
         c_dat_r    = (c_ack & ~c_we) ? rand_dat[gi*DAT_W +: DAT_W] : '0;
         wait_cnt_d = (!active || term) ? '0 : wait_cnt_q + CNT_W'(1);
      end

      always_comb begin
         state_d   = state_q;
         cap_adr_d = cap_adr_q;
         cap_we_d  = cap_we_q;
         cap_sel_d = cap_sel_q;
         cap_dat_d = cap_dat_q;
         beat_d    = beat_q;
         violation = bad_bte;

         case (state_q)
            ST_IDLE: begin
               if (active && !term) begin
                  cap_adr_d = c_adr;
                  cap_we_d  = c_we;
                  cap_sel_d = c_sel;
                  cap_dat_d = c_dat;
                  state_d   = ST_WAIT;
               end else if (c_ack && burst_req) begin
                  cap_adr_d = c_adr;
                  beat_d    = 1'b0;
                  state_d   = ST_BURST;
               end
            end

            ST_WAIT: begin
               if (!c_cyc) begin
                  state_d = ST_IDLE;
               end else if (!c_stb) begin
                  violation = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  if (!stable) violation = 1'b1;
                  if (term) begin
                     if (c_ack && burst_req) begin
                        cap_adr_d = c_adr;
                        beat_d    = 1'b0;
                        state_d   = ST_BURST;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end
               end
            end

            // beat_q marks a beat already presented but not yet terminated; before that,
            // cap_adr_q holds the previous beat's address and the new one must follow it.
            ST_BURST: begin
               if (!c_cyc) begin
                  beat_d  = 1'b0;
                  state_d = ST_IDLE;
               end else if (!c_stb) begin
                  if (beat_q) begin
                     violation = 1'b1;
                     beat_d    = 1'b0;
                     state_d   = ST_IDLE;
                  end
               end else begin
                  if (beat_q ? !stable : (c_adr != next_adr)) violation = 1'b1;
                  if (term) begin
                     beat_d = 1'b0;
                     if (c_ack && burst_req) begin
                        cap_adr_d = c_adr;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end else if (!beat_q) begin
                     cap_adr_d = c_adr;
                     cap_we_d  = c_we;
                     cap_sel_d = c_sel;
                     cap_dat_d = c_dat;
                     beat_d    = 1'b1;
                  end
               end
            end

            default: begin
               beat_d  = 1'b0;
               state_d = ST_IDLE;
            end
         endcase

         proto_err_d = proto_err_q | violation;
      end

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            cap_adr_q   <= '0;
            cap_we_q    <= 1'b0;
            cap_sel_q   <= '0;
            cap_dat_q   <= '0;
            beat_q      <= 1'b0;
            proto_err_q <= 1'b0;
         end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            cap_adr_q   <= cap_adr_d;
            cap_we_q    <= cap_we_d;
            cap_sel_q   <= cap_sel_d;
            cap_dat_q   <= cap_dat_d;
            beat_q      <= beat_d;
            proto_err_q <= proto_err_d;
         end
      end

      assign ack[gi]                      = c_ack;
      assign err[gi]                      = c_err;
      assign dat_r[gi*DAT_W +: DAT_W]     = c_dat_r;
      assign wait_cnt[gi*CNT_W +: CNT_W]  = wait_cnt_q;
      assign proto_err[gi]                = proto_err_q;
   end

endmodule
